// File: rtl/modn_counter_pkg.sv
// Shared helpers and direction encodings for the modulo-N counter family.
package modn_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Counter width for a given modulus, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

    // Binary 0..99 to two packed BCD digits, tens in the upper nibble.
    function automatic logic [7:0] bin2bcd8(input int unsigned v);
        return {4'(v / 32'd10), 4'(v % 32'd10)};
    endfunction

endpackage

// File: rtl/modn_counter_bcd_digit_pair.sv
// Two-digit BCD tracker stepped in lockstep with the binary count (clr > load > step).
module bcd_digit_pair
    import modn_counter_pkg::*;
#(
    parameter logic [7:0] RESET_BCD = 8'h00,
    parameter logic [7:0] TOP_BCD   = 8'h59
) (
    input  logic       clk,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic [7:0] i_load_bcd,
    input  logic       i_step,
    input  logic       i_up,
    input  logic       i_wrap,
    output logic [7:0] o_bcd
);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic [3:0] w_tens_nxt;
    logic [3:0] w_ones_nxt;

    always_comb begin
        w_tens_nxt = r_tens;
        w_ones_nxt = r_ones;
        if (i_load) begin
            {w_tens_nxt, w_ones_nxt} = i_load_bcd;
        end else if (i_step) begin
            if (i_wrap) begin
                {w_tens_nxt, w_ones_nxt} = (i_up == DIR_UP) ? 8'h00 : TOP_BCD;
            end else if (i_up == DIR_UP) begin
                if (r_ones == 4'd9) begin
                    w_ones_nxt = 4'd0;
                    w_tens_nxt = r_tens + 4'd1;
                end else begin
                    w_ones_nxt = r_ones + 4'd1;
                end
            end else begin
                if (r_ones == 4'd0) begin
                    w_ones_nxt = 4'd9;
                    w_tens_nxt = r_tens - 4'd1;
                end else begin
                    w_ones_nxt = r_ones - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_clr) begin
            {r_tens, r_ones} <= RESET_BCD;
        end else begin
            r_tens <= w_tens_nxt;
            r_ones <= w_ones_nxt;
        end
    end

    assign o_bcd = {r_tens, r_ones};

endmodule

// File: rtl/modn_counter.sv
// Modulo-N up/down counter with cascade carry, load clamp and registered wrap pulse.
// Optional packed-BCD output enabled by defining MODN_COUNTER_BCD_EN.
module modn_counter
    import modn_counter_pkg::*;
#(
    parameter int unsigned MODULUS   = 60,
    parameter int unsigned WIDTH     = clog2_min1(MODULUS),
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             ci,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             co,
    output logic             tc,
    output logic             load_err
`ifdef MODN_COUNTER_BCD_EN
    ,
    output logic [7:0]       bcd
`endif
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 32'd1);
    localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(RESET_VAL);

    if (MODULUS < 32'd2 || MODULUS > 32'd65536) begin : g_bad_modulus
        $error("modn_counter: MODULUS out of range 2..65536");
    end
    if ((32'd1 << WIDTH) < MODULUS) begin : g_bad_width
        $error("modn_counter: WIDTH too narrow for MODULUS");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset
        $error("modn_counter: RESET_VAL must be below MODULUS");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_co;
    logic             r_load_err;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_co_nxt;
    logic             w_err_nxt;
    logic             w_step;
    logic             w_wrap;
    logic             w_load_ok;
    logic [WIDTH-1:0] w_load_value;

    assign w_step       = en & ci;
    assign w_wrap       = (up == DIR_UP) ? (r_count == CNT_MAX) : (r_count == '0);
    assign w_load_ok    = 32'(load_val) < MODULUS;
    assign w_load_value = w_load_ok ? load_val : CNT_MAX;

    // Next count/flags under load > advance > hold; clr is applied in the register.
    always_comb begin
        w_count_nxt = r_count;
        w_co_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        if (load) begin
            w_count_nxt = w_load_value;
            w_err_nxt   = ~w_load_ok;
        end else if (w_step) begin
            if (w_wrap) begin
                w_count_nxt = (up == DIR_UP) ? '0 : CNT_MAX;
                w_co_nxt    = 1'b1;
            end else if (up == DIR_UP) begin
                w_count_nxt = r_count + WIDTH'(1);
            end else begin
                w_count_nxt = r_count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count    <= CNT_RST;
            r_co       <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_co       <= w_co_nxt;
            r_load_err <= w_err_nxt;
        end
    end

    assign count    = r_count;
    assign co       = r_co;
    assign load_err = r_load_err;
    // Ungated by clr/load so a downstream stage sees carry with zero latency.
    assign tc       = w_step & w_wrap;

`ifdef MODN_COUNTER_BCD_EN
    if (MODULUS > 32'd100) begin : g_bad_bcd
        $error("modn_counter: BCD output requires MODULUS <= 100");
    end

    bcd_digit_pair #(
        .RESET_BCD (bin2bcd8(RESET_VAL)),
        .TOP_BCD   (bin2bcd8(MODULUS - 32'd1))
    ) u_bcd (
        .clk        (clk),
        .i_clr      (clr),
        .i_load     (load),
        .i_load_bcd (bin2bcd8(32'(w_load_value))),
        .i_step     (w_step),
        .i_up       (up),
        .i_wrap     (w_wrap),
        .o_bcd      (bcd)
    );
`endif

endmodule

// File: tb/tb_modn_counter.sv
// Directed self-checking bench for modn_counter (mod-60 main, mod-4 natural wrap, sec/min cascade).
module tb_modn_counter;

    logic       clk = 1'b0;
    logic       clr, en, ci, up, load;
    logic [5:0] load_val;
    logic [5:0] count;
    logic       co, tc, load_err;

    logic       m4_en, m4_up;
    logic [1:0] m4_count;
    logic       m4_co, m4_tc, m4_err;

    logic       sec_en, gate;
    logic [5:0] sec_count, min_count;
    logic       sec_co, sec_tc, sec_err, min_co, min_tc, min_err;

`ifdef MODN_COUNTER_BCD_EN
    logic [7:0] bcd, m4_bcd, sec_bcd, min_bcd;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    modn_counter #(.MODULUS(60)) u_dut (
        .clk(clk), .clr(clr), .en(en), .ci(ci), .up(up), .load(load), .load_val(load_val),
        .count(count), .co(co), .tc(tc), .load_err(load_err)
`ifdef MODN_COUNTER_BCD_EN
        , .bcd(bcd)
`endif
    );

    modn_counter #(.MODULUS(4)) u_m4 (
        .clk(clk), .clr(clr), .en(m4_en), .ci(1'b1), .up(m4_up), .load(1'b0), .load_val(2'd0),
        .count(m4_count), .co(m4_co), .tc(m4_tc), .load_err(m4_err)
`ifdef MODN_COUNTER_BCD_EN
        , .bcd(m4_bcd)
`endif
    );

    modn_counter #(.MODULUS(60)) u_sec (
        .clk(clk), .clr(clr), .en(sec_en), .ci(1'b1), .up(1'b1), .load(1'b0), .load_val(6'd0),
        .count(sec_count), .co(sec_co), .tc(sec_tc), .load_err(sec_err)
`ifdef MODN_COUNTER_BCD_EN
        , .bcd(sec_bcd)
`endif
    );

    modn_counter #(.MODULUS(60)) u_min (
        .clk(clk), .clr(clr), .en(1'b1), .ci(sec_tc & gate), .up(1'b1), .load(1'b0), .load_val(6'd0),
        .count(min_count), .co(min_co), .tc(min_tc), .load_err(min_err)
`ifdef MODN_COUNTER_BCD_EN
        , .bcd(min_bcd)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; en = 1'b0; ci = 1'b0; up = 1'b1; load = 1'b0; load_val = 6'd0;
        m4_en = 1'b0; m4_up = 1'b1; sec_en = 1'b0; gate = 1'b0;
        tick();
        tick();
        checks++;
        if (count !== 6'd0 || co !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d co=%b err=%b, want 0 0 0", count, co, load_err);
        end
        clr = 1'b0;
    endtask

    task automatic test_count_up();
        int exp_cnt = 0;
        en = 1'b1; ci = 1'b1; up = 1'b1;
        for (int i = 0; i < 60; i++) begin
            #1;
            checks++;
            if (tc !== (exp_cnt == 59)) begin
                errors++;
                $display("FAIL up_tc: count=%0d tc=%b want %b", count, tc, (exp_cnt == 59));
            end
            tick();
            exp_cnt = (exp_cnt + 1) % 60;
            checks++;
            if (count !== 6'(exp_cnt) || co !== (exp_cnt == 0)) begin
                errors++;
                $display("FAIL up_step: count=%0d co=%b want %0d %b", count, co, exp_cnt, (exp_cnt == 0));
            end
        end
    endtask

    task automatic test_count_down();
        up = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL down_tc0: tc=%b want 1", tc);
        end
        tick();
        checks++;
        if (count !== 6'd59 || co !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap: count=%0d co=%b want 59 1", count, co);
        end
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL down_tc59: tc=%b want 0", tc);
        end
        tick();
        checks++;
        if (count !== 6'd58 || co !== 1'b0) begin
            errors++;
            $display("FAIL down_step: count=%0d co=%b want 58 0", count, co);
        end
        en = 1'b0;
        tick();
        checks++;
        if (count !== 6'd58 || co !== 1'b0) begin
            errors++;
            $display("FAIL hold: count=%0d co=%b want 58 0", count, co);
        end
    endtask

    task automatic test_load();
        load = 1'b1; load_val = 6'd75 - 6'd0; en = 1'b1; ci = 1'b1; up = 1'b1;
        load_val = 6'd59;
        load_val = 6'b001011 + 6'd64 - 6'd0;
        load = 1'b1;
        load_val = 6'd63;
        tick();
        checks++;
        if (count !== 6'd59 || load_err !== 1'b1 || co !== 1'b0) begin
            errors++;
            $display("FAIL load_oor: count=%0d err=%b co=%b want 59 1 0", count, load_err, co);
        end
        load_val = 6'd12;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL load_tc: tc=%b want 1", tc);
        end
        tick();
        checks++;
        if (count !== 6'd12 || load_err !== 1'b0 || co !== 1'b0) begin
            errors++;
            $display("FAIL load_ok: count=%0d err=%b co=%b want 12 0 0", count, load_err, co);
        end
        load = 1'b0; en = 1'b0;
        tick();
        checks++;
        if (count !== 6'd12 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL load_release: count=%0d err=%b want 12 0", count, load_err);
        end
    endtask

    task automatic test_clr_priority();
        load = 1'b1; load_val = 6'd59;
        tick();
        load = 1'b0; en = 1'b1; ci = 1'b1; up = 1'b1; clr = 1'b1;
        tick();
        checks++;
        if (count !== 6'd0 || co !== 1'b0) begin
            errors++;
            $display("FAIL clr_wrap: count=%0d co=%b want 0 0", count, co);
        end
        clr = 1'b0; load = 1'b1; load_val = 6'd37; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; clr = 1'b1;
        tick();
        checks++;
        if (count !== 6'd0 || co !== 1'b0) begin
            errors++;
            $display("FAIL clr_mid: count=%0d co=%b want 0 0", count, co);
        end
        load = 1'b1; load_val = 6'd20;
        tick();
        checks++;
        if (count !== 6'd0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_load: count=%0d err=%b want 0 0", count, load_err);
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_pow2_wrap();
        int exp_cnt = 0;
        m4_en = 1'b1; m4_up = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (m4_tc !== (exp_cnt == 3)) begin
                errors++;
                $display("FAIL m4_tc: count=%0d tc=%b want %b", m4_count, m4_tc, (exp_cnt == 3));
            end
            tick();
            exp_cnt = (exp_cnt + 1) % 4;
            checks++;
            if (m4_count !== 2'(exp_cnt) || m4_co !== (exp_cnt == 0)) begin
                errors++;
                $display("FAIL m4_up: count=%0d co=%b want %0d %b", m4_count, m4_co, exp_cnt, (exp_cnt == 0));
            end
        end
        m4_up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_cnt = (exp_cnt + 3) % 4;
            checks++;
            if (m4_count !== 2'(exp_cnt) || m4_co !== (exp_cnt == 3)) begin
                errors++;
                $display("FAIL m4_down: count=%0d co=%b want %0d %b", m4_count, m4_co, exp_cnt, (exp_cnt == 3));
            end
        end
        m4_en = 1'b0;
    endtask

    task automatic test_cascade();
        int pulses = 0;
        int last = -1;
        clr = 1'b1;
        tick();
        clr = 1'b0; sec_en = 1'b1; gate = 1'b1;
        for (int i = 1; i <= 3600; i++) begin
            tick();
            if (min_co === 1'b1) begin
                pulses++;
                last = i;
            end
        end
        checks++;
        if (pulses != 1 || last != 3600) begin
            errors++;
            $display("FAIL cascade_co: pulses=%0d at=%0d want 1 at 3600", pulses, last);
        end
        checks++;
        if (sec_count !== 6'd0 || min_count !== 6'd0) begin
            errors++;
            $display("FAIL cascade_cnt: sec=%0d min=%0d want 0 0", sec_count, min_count);
        end
        gate = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        checks++;
        if (min_count !== 6'd0 || sec_count !== 6'd0) begin
            errors++;
            $display("FAIL cascade_hold: sec=%0d min=%0d want 0 0", sec_count, min_count);
        end
        sec_en = 1'b0;
    endtask

`ifdef MODN_COUNTER_BCD_EN
    task automatic test_bcd();
        load = 1'b1; load_val = 6'd45;
        tick();
        checks++;
        if (bcd !== 8'h45) begin
            errors++;
            $display("FAIL bcd_45: bcd=%h want 45", bcd);
        end
        load_val = 6'd59;
        tick();
        load = 1'b0; en = 1'b1; ci = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (bcd !== 8'h00 || count !== 6'd0) begin
            errors++;
            $display("FAIL bcd_wrap: bcd=%h count=%0d want 00 0", bcd, count);
        end
        load = 1'b1; load_val = 6'd63; en = 1'b0;
        tick();
        checks++;
        if (bcd !== 8'h59) begin
            errors++;
            $display("FAIL bcd_clamp: bcd=%h want 59", bcd);
        end
        load = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_clr_priority();
        test_pow2_wrap();
        test_cascade();
`ifdef MODN_COUNTER_BCD_EN
        test_bcd();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
